imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes instruction memory from a byte stream. It accepts a framed byte stream (word count, little-endian instruction words, optional checksum) over a valid/ready handshake. It writes each assembled 32-bit word into the instruction RAM write port and holds the core in reset until the image is complete. It sits in the SoC between a host-facing byte source (UART RX or debug bridge) and the instruction memory that the core fetches from.

## Interface
Parameters:
- MEM_DEPTH, 16, width of the instruction-memory byte address.
- LOAD_BASE, 16'h0, byte address of the first written word; must be 4-byte aligned.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  out  MEM_DEPTH  byte address of the write.
- imem_wdata  out  32  write data.
- core_hold  out  1  high keeps the core in reset.
- done  out  1  image loaded successfully; sticky.
- error  out  1  checksum mismatch; sticky.

## Operation
- A byte is transferred on a clock edge where s_valid && s_ready. Without a transfer, no state changes.
- Frame format, little-endian throughout:
  - 2 header bytes: N = word count, 16 bit.
  - N×4 data bytes.
  - With the checksum feature compiled in (see Configuration), 1 trailing checksum byte.
- States:
  - HDR0: capture N[7:0] → HDR1.
  - HDR1: capture N[15:8]. If N==0 → CSUM (or DONE when the checksum is compiled out); else → DATA.
  - DATA: shift bytes into a 32-bit assembly register, LSB first, with a 2-bit byte counter. After the 4th byte: issue a write and increment the word counter. When word counter == N → CSUM (or DONE).
  - CSUM: compare the byte with the running checksum. Equal → DONE; not equal → ERROR.
  - DONE and ERROR: terminal. They are left only by reset.
- s_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERROR.
- Write k (k = 0..N-1): imem_waddr = LOAD_BASE + 4k, truncated to MEM_DEPTH bits, so it wraps modulo 2^MEM_DEPTH. imem_wdata = {b3,b2,b1,b0}.
- core_hold = 1 in every state except DONE. The core is never released on ERROR.
- Reset outputs: s_ready 0 during reset and 1 on the first cycle after reset. imem_we 0, imem_waddr LOAD_BASE, imem_wdata 0, core_hold 1, done 0, error 0. State is HDR0 and all counters are 0.
- Reset asserted mid-frame discards the partial word and counters. No write is issued for the partial word, and core_hold returns to 1 asynchronously.

## Timing
- All outputs are registered.
- A byte is accepted every cycle while s_valid stays high; there are no bubbles.
- imem_we / imem_waddr / imem_wdata are valid the cycle after the handshake of the 4th byte of a word.
- imem_we is high for exactly 1 cycle per word. Back-to-back words can produce writes 4 cycles apart.
- The state register enters DONE on the same edge that registers the final write (or on the checksum-byte edge). done rises on that edge.
- core_hold falls one cycle later. This guarantees the last write completes before the core leaves reset.
- error rises on the edge that accepts a bad checksum byte.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The frame carries a trailing checksum byte, equal to the XOR of all header and data bytes.
  - The CSUM state exists and mismatch drives ERROR.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No checksum byte; the frame ends after the last data byte (or after HDR1 when N=0).
  - CSUM and ERROR are unreachable, and error is tied to 0.

## Test plan
- Reset values: hold reset low, then release → s_ready=1, core_hold=1, done=0, error=0, imem_we=0.
- Two-word load, macro defined, LOAD_BASE=0:
  - Stimulus: bytes 02 00 13 05 10 00 93 05 20 00, then checksum = XOR of all those bytes.
  - Required: writes (0x0000, 0x00100513) and (0x0004, 0x00200593); done=1; core_hold drops 1 cycle after the final transition; s_ready=0 afterwards.
- Bad checksum: same frame with the checksum XOR 0x01 → both writes still occur; error=1, core_hold stays 1, s_ready=0.
- Zero-length and throttling:
  - N=0 (bytes 00 00, checksum 00) → no writes, done=1.
  - s_valid toggled on random cycles → identical writes; nothing is accepted while s_valid=0.
- Address wrap: MEM_DEPTH=4, LOAD_BASE=4'hC, N=2 → writes at 0xC then 0x0.
- Reset mid-word:
  - Stimulus: reset asserted after 2 data bytes, then a fresh one-word frame.
  - Required: no write before reset; the single write lands at LOAD_BASE with the new data.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: framed little-endian byte stream -> 32-bit instruction-memory writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          MEM_DEPTH = 16,
  parameter logic [15:0] LOAD_BASE = 16'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 imem_we,
  output logic [MEM_DEPTH-1:0] imem_waddr,
  output logic [31:0]          imem_wdata,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERROR} state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e TAIL = CSUM;
`else
  localparam state_e TAIL = DONE;
`endif

  state_e               state_q, state_d;
  logic [15:0]          count_q;
  logic [15:0]          wordCnt_q;
  logic [15:0]          wordCnt_d;
  logic [1:0]           byteCnt_q;
  logic [31:0]          asmWord_q;
  logic [31:0]          asmWord_d;
  logic [MEM_DEPTH-1:0] nextAddr_q;
  logic                 s_ready_q;
  logic                 imem_we_q;
  logic [MEM_DEPTH-1:0] imem_waddr_q;
  logic [31:0]          imem_wdata_q;
  logic                 core_hold_q;
  logic                 done_q;
  logic                 xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
  logic                 error_q;
`endif

  assign xfer      = s_valid && s_ready_q;
  assign wordCnt_d = wordCnt_q + 16'd1;
  assign asmWord_d = {s_data, asmWord_q[31:8]};

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        HDR0: state_d = HDR1;
        HDR1: state_d = ({s_data, count_q[7:0]} == 16'd0) ? TAIL : DATA;
        DATA: begin
          if (byteCnt_q == 2'd3 && wordCnt_d == count_q) state_d = TAIL;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: state_d = (s_data == csum_q) ? DONE : ERROR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // core_hold lags the state by one edge so the final write lands before release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= HDR0;
      count_q      <= 16'd0;
      wordCnt_q    <= 16'd0;
      byteCnt_q    <= 2'd0;
      asmWord_q    <= 32'd0;
      nextAddr_q   <= MEM_DEPTH'(LOAD_BASE);
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= MEM_DEPTH'(LOAD_BASE);
      imem_wdata_q <= 32'd0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_ready_q   <= (state_d != DONE) && (state_d != ERROR);
      done_q      <= (state_d == DONE);
      core_hold_q <= (state_q != DONE);
      imem_we_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error_q     <= (state_d == ERROR);
      if (xfer && (state_q == HDR0 || state_q == HDR1 || state_q == DATA))
        csum_q <= csum_q ^ s_data;
`endif
      if (xfer && state_q == HDR0) count_q[7:0] <= s_data;
      if (xfer && state_q == HDR1) count_q[15:8] <= s_data;
      if (xfer && state_q == DATA) begin
        asmWord_q <= asmWord_d;
        byteCnt_q <= byteCnt_q + 2'd1;
        if (byteCnt_q == 2'd3) begin
          imem_we_q    <= 1'b1;
          imem_waddr_q <= nextAddr_q;
          imem_wdata_q <= asmWord_d;
          nextAddr_q   <= nextAddr_q + MEM_DEPTH'(4);
          wordCnt_q    <= wordCnt_d;
        end
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule
